// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths, x0 constant and query result type for the register file
package reg_file_pkg;

    localparam int ROB_POS_W = 4;
    localparam int REG_NUM   = 32;
    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                 busy;
        logic [ROB_POS_W-1:0] rob_pos;
        logic [XLEN-1:0]      val;
    } query_t;

endpackage

// File: rtl/reg_file.sv
// reg_file: architectural registers with busy/rename tags and commit-bypassed source lookups
module reg_file
    import reg_file_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 issue,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [ROB_POS_W-1:0] issue_rob_pos,
    input  logic                 reg_write,
    input  logic [REG_IDX_W-1:0] reg_rd,
    input  logic [XLEN-1:0]      reg_val,
    input  logic [ROB_POS_W-1:0] commit_rob_pos,
    input  logic [REG_IDX_W-1:0] rs1_idx,
    input  logic [REG_IDX_W-1:0] rs2_idx,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [XLEN-1:0]      rs1_val,
    output logic [XLEN-1:0]      rs2_val,
    output logic [ROB_POS_W-1:0] rs1_rob_pos,
    output logic [ROB_POS_W-1:0] rs2_rob_pos
);

    logic [XLEN-1:0]      val [REG_NUM];
    logic [ROB_POS_W-1:0] tag [REG_NUM];
    logic [REG_NUM-1:0]   busy;

    query_t q1, q2;

    // Source lookup: a commit retiring the youngest writer forwards its value and clears busy
    function automatic query_t lookup(input logic [REG_IDX_W-1:0] idx);
        logic hit;
        hit = reg_write && reg_rd == idx && idx != ZERO_REG && busy[idx] && tag[idx] == commit_rob_pos;
        lookup.busy    = hit ? 1'b0 : busy[idx];
        lookup.rob_pos = tag[idx];
        lookup.val     = hit ? reg_val : val[idx];
    endfunction

    assign q1 = lookup(rs1_idx);
    assign q2 = lookup(rs2_idx);

    assign rs1_busy    = q1.busy;
    assign rs1_rob_pos = q1.rob_pos;
    assign rs1_val     = q1.val;
    assign rs2_busy    = q2.busy;
    assign rs2_rob_pos = q2.rob_pos;
    assign rs2_val     = q2.val;

    // State update: commit first, then rollback or issue; later assignments win so issue beats commit on busy/tag
    always_ff @(posedge clk) begin
        if (rst) begin
            val  <= '{default: '0};
            tag  <= '{default: '0};
            busy <= '0;
        end else if (rdy) begin
            if (reg_write && reg_rd != ZERO_REG) begin
                val[reg_rd] <= reg_val;
                if (tag[reg_rd] == commit_rob_pos) busy[reg_rd] <= 1'b0;
            end
            if (rollback) busy <= '0;
            else if (issue && issue_rd != ZERO_REG) begin
                busy[issue_rd] <= 1'b1;
                tag[issue_rd]  <= issue_rob_pos;
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed plan plus randomized traffic against an array-based reference model
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, issue, reg_write;
    logic [4:0]  issue_rd, reg_rd, rs1_idx, rs2_idx;
    logic [3:0]  issue_rob_pos, commit_rob_pos;
    logic [31:0] reg_val;
    logic        rs1_busy, rs2_busy;
    logic [31:0] rs1_val, rs2_val;
    logic [3:0]  rs1_rob_pos, rs2_rob_pos;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_val  [32];
    logic [3:0]  m_tag  [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    reg_file dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
        .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val), .commit_rob_pos(commit_rob_pos),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .rs1_rob_pos(rs1_rob_pos), .rs2_rob_pos(rs2_rob_pos)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_val[i]) begin
            m_val[i]  = '0;
            m_tag[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic void expect_q(input logic [4:0] idx, output logic b, output logic [3:0] p, output logic [31:0] v);
        b = m_busy[idx];
        p = m_tag[idx];
        v = m_val[idx];
        if (reg_write && reg_rd == idx && idx != 0 && m_busy[idx] && m_tag[idx] == commit_rob_pos) begin
            b = 1'b0;
            v = reg_val;
        end
    endfunction

    task automatic cmp_ports();
        logic b;
        logic [3:0] p;
        logic [31:0] v;
        expect_q(rs1_idx, b, p, v);
        check("rs1_busy", 32'(rs1_busy), 32'(b));
        check("rs1_val", rs1_val, v);
        if (b) check("rs1_rob_pos", 32'(rs1_rob_pos), 32'(p));
        expect_q(rs2_idx, b, p, v);
        check("rs2_busy", 32'(rs2_busy), 32'(b));
        check("rs2_val", rs2_val, v);
        if (b) check("rs2_rob_pos", 32'(rs2_rob_pos), 32'(p));
    endtask

    task automatic model_update();
        if (rst) model_reset();
        else if (rdy) begin
            if (reg_write && reg_rd != 0) begin
                m_val[reg_rd] = reg_val;
                if (m_tag[reg_rd] == commit_rob_pos) m_busy[reg_rd] = 1'b0;
            end
            if (rollback) foreach (m_busy[i]) m_busy[i] = 1'b0;
            else if (issue && issue_rd != 0) begin
                m_busy[issue_rd] = 1'b1;
                m_tag[issue_rd]  = issue_rob_pos;
            end
        end
    endtask

    task automatic tick();
        #2;
        if (!rst) cmp_ports();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst = 0; rdy = 1; rollback = 0; issue = 0; reg_write = 0;
        issue_rd = 0; issue_rob_pos = 0; reg_rd = 0; reg_val = 0; commit_rob_pos = 0;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [3:0] pos);
        idle();
        issue = 1; issue_rd = rd; issue_rob_pos = pos;
        tick();
    endtask

    initial begin
        idle();
        rs1_idx = 0; rs2_idx = 0;
        rst = 1;
        @(posedge clk);
        model_reset();
        #1;
        do_issue(0, 7);
        idle(); rs1_idx = 5; rs2_idx = 0; #1;
        check("rst_x5_busy", 32'(rs1_busy), 0);
        check("rst_x5_val", rs1_val, 0);
        check("x0_busy", 32'(rs2_busy), 0);
        check("x0_val", rs2_val, 0);

        do_issue(5, 3);
        idle(); #1;
        check("x5_busy", 32'(rs1_busy), 1);
        check("x5_pos", 32'(rs1_rob_pos), 3);
        reg_write = 1; reg_rd = 5; commit_rob_pos = 3; reg_val = 32'h1234; #1;
        check("x5_byp_busy", 32'(rs1_busy), 0);
        check("x5_byp_val", rs1_val, 32'h1234);
        tick();
        idle(); #1;
        check("x5_state_busy", 32'(rs1_busy), 0);
        check("x5_state_val", rs1_val, 32'h1234);

        do_issue(7, 2);
        do_issue(7, 6);
        idle(); rs1_idx = 7;
        reg_write = 1; reg_rd = 7; commit_rob_pos = 2; reg_val = 32'hAA; #1;
        check("x7_old_commit_busy", 32'(rs1_busy), 1);
        tick();
        idle(); #1;
        check("x7_still_busy", 32'(rs1_busy), 1);
        check("x7_pos", 32'(rs1_rob_pos), 6);
        check("x7_val_aa", rs1_val, 32'hAA);
        reg_write = 1; reg_rd = 7; commit_rob_pos = 6; reg_val = 32'hBB;
        tick();
        idle(); #1;
        check("x7_free", 32'(rs1_busy), 0);
        check("x7_val_bb", rs1_val, 32'hBB);

        do_issue(9, 1);
        idle(); rs1_idx = 9;
        issue = 1; issue_rd = 9; issue_rob_pos = 4;
        reg_write = 1; reg_rd = 9; commit_rob_pos = 1; reg_val = 32'h55; #1;
        check("x9_byp_busy", 32'(rs1_busy), 0);
        check("x9_byp_val", rs1_val, 32'h55);
        tick();
        idle(); #1;
        check("x9_busy", 32'(rs1_busy), 1);
        check("x9_pos", 32'(rs1_rob_pos), 4);
        check("x9_val", rs1_val, 32'h55);

        do_issue(3, 8);
        do_issue(4, 9);
        do_issue(8, 10);
        idle();
        rollback = 1; reg_write = 1; reg_rd = 3; commit_rob_pos = 8; reg_val = 32'h77;
        issue = 1; issue_rd = 12; issue_rob_pos = 11;
        tick();
        idle(); rs1_idx = 3; rs2_idx = 4; #1;
        check("rb_x3_busy", 32'(rs1_busy), 0);
        check("rb_x3_val", rs1_val, 32'h77);
        check("rb_x4_busy", 32'(rs2_busy), 0);
        rs1_idx = 8; rs2_idx = 12; #1;
        check("rb_x8_busy", 32'(rs1_busy), 0);
        check("rb_x12_dropped", 32'(rs2_busy), 0);

        for (int pass = 0; pass < 2; pass++) begin
            idle();
            rdy = (pass == 1);
            issue = 1; issue_rd = 10; issue_rob_pos = 5;
            reg_write = 1; reg_rd = 11; commit_rob_pos = 0; reg_val = 32'h99;
            tick();
            idle(); rs1_idx = 10; rs2_idx = 11; #1;
            check(pass ? "rdy_x10_busy" : "hold_x10_busy", 32'(rs1_busy), 32'(pass));
            check(pass ? "rdy_x11_val" : "hold_x11_val", rs2_val, pass ? 32'h99 : 32'h0);
        end
        check("rdy_x10_pos", 32'(rs1_rob_pos), 5);

        idle(); reg_write = 1; reg_rd = 0; reg_val = 32'hFFFF_FFFF;
        tick();
        idle(); rs1_idx = 0; #1;
        check("x0_write_ignored", rs1_val, 0);

        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 199) == 0);
            rdy            = ($urandom_range(0, 9) != 0);
            rollback       = ($urandom_range(0, 29) == 0);
            issue          = 1'($urandom);
            issue_rd       = 5'($urandom_range(0, 7));
            issue_rob_pos  = 4'($urandom);
            reg_write      = 1'($urandom);
            reg_rd         = 5'($urandom_range(0, 7));
            commit_rob_pos = $urandom_range(0, 1) ? m_tag[reg_rd] : 4'($urandom);
            reg_val        = $urandom;
            rs1_idx        = 5'($urandom_range(0, 7));
            rs2_idx        = ($urandom_range(0, 3) == 0) ? reg_rd : 5'($urandom);
            tick();
        end

        idle(); rst = 1;
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            rs1_idx = 5'(i); #1;
            if (i % 8 == 0) begin
                check("final_rst_busy", 32'(rs1_busy), 0);
                check("final_rst_val", rs1_val, 0);
                check("final_rst_pos", 32'(rs1_rob_pos), 0);
            end else cmp_ports();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with rename tags for the out-of-order RISC-V core. Holds the 32 committed integer register values and, per register, a busy flag plus the reorder-buffer position of the youngest in-flight writer. Sits on the receiving end of the reorder buffer's commit port (`reg_write`/`reg_rd`/`reg_val`/`commit_rob_pos`) and on the issue path from the decoder. Answers the decoder's source-operand lookups combinationally.

## Interface
- `ROB_POS_W`, 4: width of a reorder-buffer position (16 entries).
- `REG_NUM`, 32: number of architectural registers; index width 5.
- `clk`  in  1  clock.
- `rst`  in  1  reset rst, synchronous, active-high; clock clk.
- `rdy`  in  1  global enable; when low, all state holds.
- `rollback`  in  1  mispredict flush from the reorder buffer.
- `issue`  in  1  decoder issues an instruction that writes `issue_rd` this cycle.
- `issue_rd`  in  5  destination register of the issuing instruction.
- `issue_rob_pos`  in  4  reorder-buffer slot allocated to it.
- `reg_write`  in  1  commit write strobe from the reorder buffer.
- `reg_rd`  in  5  committed destination.
- `reg_val`  in  32  committed value.
- `commit_rob_pos`  in  4  reorder-buffer slot being committed.
- `rs1_idx`, `rs2_idx`  in  5 each  source register indices from the decoder.
- `rs1_busy`, `rs2_busy`  out  1 each  source awaits an in-flight writer.
- `rs1_val`, `rs2_val`  out  32 each  committed value; valid when not busy.
- `rs1_rob_pos`, `rs2_rob_pos`  out  4 each  tag of the youngest writer; valid when busy.

## Operation
- State per register: `val[32]`, `busy`, `tag[4]`. x0: `val`=0, `busy`=0 permanently. Writes and issues to x0 are ignored.
- Commit: if `reg_write` and `reg_rd`≠0, then `val[reg_rd]`←`reg_val` unconditionally. `busy[reg_rd]` clears only when `tag[reg_rd]`==`commit_rob_pos`. A mismatch means a younger writer exists, so busy stays set.
- Issue: if `issue` and `issue_rd`≠0, then `busy[issue_rd]`←1 and `tag[issue_rd]`←`issue_rob_pos`.
- Issue and commit to the same rd in the same cycle: the value is written, and the issue wins. Busy stays 1 and the tag takes the new position.
- Rollback: clears every `busy`. Tags are don't-care; values are retained. A commit write in the same cycle as `rollback` still updates `val`, which is required for JALR commit-and-flush. A concurrent `issue` is discarded.
- Query, combinational:
  - Default: `rsN_busy`=`busy[idx]`, `rsN_rob_pos`=`tag[idx]`, `rsN_val`=`val[idx]`.
  - Commit bypass: if `reg_write`, `reg_rd`==`idx`≠0, and `tag[idx]`==`commit_rob_pos` with `busy` set, then `rsN_busy`=0 and `rsN_val`=`reg_val`.
  - The same-cycle issue never affects a query. Sources are read before the issuing instruction's own rename.
- `rdy` low: no state updates. Queries still reflect current state plus the bypass.

## Timing
- Reset, one cycle with `rst` high: all `val`=0, all `busy`=0, all `tag`=0. Immediately afterwards every query returns busy=0, val=0, rob_pos=0.
- Reset has priority over `rollback` and `rdy`.
- Issue rename is visible to queries on the cycle after `issue`.
- A commit write is visible the same cycle via the bypass, and from state on the next cycle.
- Rollback takes effect at the clock edge where it is sampled high. The next cycle shows all registers not busy.
- No handshakes and no back-pressure. Inputs are trusted single-cycle strobes.

## Structure
- `ROB_POS_W`, the register-index width, and x0 handling constants belong in the shared `constant.v`.
- One flat module. No sub-module is warranted: the two query ports are identical combinational muxes, written as a generate or a function.
- Target size is roughly 120–160 lines.

## Test plan
- Reset, then query x5 -> busy=0, val=0. Query x0 with a prior issue to x0 -> still busy=0, val=0.
- Issue rd=5 pos=3. Next cycle query x5 -> busy=1, rob_pos=3. Commit rd=5 pos=3 val=0x1234 -> same-cycle query shows busy=0, val=0x1234. Next cycle the value comes from state.
- Issue rd=7 pos=2, then issue rd=7 pos=6. Commit rd=7 pos=2 val=0xAA -> x7 stays busy with rob_pos=6; internal val=0xAA. Commit pos=6 val=0xBB -> not busy, val=0xBB.
- Same cycle: issue rd=9 pos=4 and commit rd=9 pos=1 (tag 1) val=0x55 -> next cycle busy=1, rob_pos=4. The same-cycle query of x9 shows busy=0, val=0x55 via the bypass.
- Issue rd=3,4,8. Then `rollback` together with commit rd=3 val=0x77 (tag matches) -> next cycle x3, x4, x8 are all not busy and x3 reads 0x77.
- `rdy`=0 with issue and commit asserted -> no state change. Raise `rdy` and repeat -> the updates apply.
